// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads with extension, and sub-word stores via read-modify-write.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_M,
  input  logic        req_write_M,
  input  logic [1:0]  req_size_M,
  input  logic        req_signed_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic        Mem_Read_M,
  output logic        Mem_Write_M,
  output logic [31:0] ALU_result_M,
  output logic [31:0] Write_Data_M,
  input  logic [31:0] mem_read_M,
  output logic [31:0] load_data_M,
  output logic        done_M,
  output logic        stall_M,
  output logic        misalign_M
);

  typedef enum logic {S_IDLE, S_MERGE} state_t;

  state_t      r_state;
  logic [31:0] r_word;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_half;
  logic [31:0] r_load_data;
  logic        r_done;
  logic        r_misalign;

  logic        w_idle;
  logic        w_accept;
  logic        w_is_word;
  logic        w_is_half;
  logic        w_misalign;
  logic        w_sub_store;
  logic [31:0] w_addr;
  logic [31:0] w_extract;
  logic [31:0] w_merged;

  function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] a,
                                               input logic [1:0] size, input logic sgn);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] res;
    h = word[{a[1], 4'b0000} +: 16];
    b = word[{a, 3'b000} +: 8];
    if (size[1])
      res = word;
    else if (size[0])
      res = {{16{sgn & h[15]}}, h};
    else
      res = {{24{sgn & b[7]}}, b};
    return res;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] a,
                                             input logic half, input logic [15:0] data);
    logic [31:0] res;
    res = word;
    if (half)
      res[{a[1], 4'b0000} +: 16] = data;
    else
      res[{a, 3'b000} +: 8] = data[7:0];
    return res;
  endfunction

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = req_valid_M && w_idle && !rst;
  assign w_is_word = req_size_M[1];
  assign w_is_half = (req_size_M == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (w_is_half && addr_M[0]) || (w_is_word && (addr_M[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_sub_store = req_write_M && !w_is_word && !w_misalign;
  assign w_addr      = w_idle ? addr_M : r_addr;
  assign w_extract   = extract_lane(mem_read_M, addr_M[1:0], req_size_M, req_signed_M);
  assign w_merged    = merge_lane(r_word, r_addr[1:0], r_half, r_wdata);

  // Strobes are combinational so the memory sees them in the accept cycle; rst masks them.
  assign stall_M      = !w_idle && !rst;
  assign Mem_Read_M   = w_accept && !w_misalign && (!req_write_M || w_sub_store);
  assign Mem_Write_M  = stall_M || (w_accept && !w_misalign && req_write_M && w_is_word);
  assign ALU_result_M = {2'b00, w_addr[31:2]};
  assign Write_Data_M = w_idle ? wdata_M : w_merged;

  assign load_data_M  = r_load_data;
  assign done_M       = r_done;
  assign misalign_M   = r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_half      <= 1'b0;
      r_load_data <= '0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid_M) begin
            if (w_misalign) begin
              r_done      <= 1'b1;
              r_misalign  <= 1'b1;
              r_load_data <= '0;
            end else if (w_sub_store) begin
              r_word  <= mem_read_M;
              r_addr  <= addr_M;
              r_wdata <= wdata_M[15:0];
              r_half  <= w_is_half;
              r_state <= S_MERGE;
            end else begin
              r_done <= 1'b1;
              if (!req_write_M)
                r_load_data <= w_extract;
            end
          end
        end
        S_MERGE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-addressed reference memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_M;
  logic        req_write_M;
  logic [1:0]  req_size_M;
  logic        req_signed_M;
  logic [31:0] addr_M;
  logic [31:0] wdata_M;
  logic        Mem_Read_M;
  logic        Mem_Write_M;
  logic [31:0] ALU_result_M;
  logic [31:0] Write_Data_M;
  logic [31:0] mem_read_M;
  logic [31:0] load_data_M;
  logic        done_M;
  logic        stall_M;
  logic        misalign_M;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_w [0:15];
  logic [7:0]  ref_b [0:63];
  logic [31:0] exp_ld;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid_M(req_valid_M), .req_write_M(req_write_M), .req_size_M(req_size_M),
    .req_signed_M(req_signed_M), .addr_M(addr_M), .wdata_M(wdata_M),
    .Mem_Read_M(Mem_Read_M), .Mem_Write_M(Mem_Write_M), .ALU_result_M(ALU_result_M),
    .Write_Data_M(Write_Data_M), .mem_read_M(mem_read_M), .load_data_M(load_data_M),
    .done_M(done_M), .stall_M(stall_M), .misalign_M(misalign_M)
  );

  assign mem_read_M = mem_w[ALU_result_M[3:0]];
  always @(posedge clk) if (Mem_Write_M) mem_w[ALU_result_M[3:0]] <= Write_Data_M;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    int unsigned nb, base;
    logic mis, sub;
    logic [31:0] val;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = a - (a % nb);
    mis  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis  = (a % nb) != 0;
`endif
    sub  = w && (nb < 4) && !mis;

    @(negedge clk);
    req_valid_M = 1'b1; req_write_M = w; req_size_M = sz; req_signed_M = sg;
    addr_M = a; wdata_M = d;
    #1;
    check_eq("acc_stall", {31'b0, stall_M}, 32'd0);
    check_eq("acc_rd", {31'b0, Mem_Read_M}, {31'b0, !mis && (!w || sub)});
    check_eq("acc_wr", {31'b0, Mem_Write_M}, {31'b0, !mis && w && !sub});
    if (!mis) check_eq("acc_idx", ALU_result_M, a >> 2);
    if (w && !sub && !mis) check_eq("acc_wdata", Write_Data_M, d);

    if (w && !mis) begin
      for (int unsigned k = 0; k < nb; k++) ref_b[base + k] = d[8*k +: 8];
    end else if (!w) begin
      val = '0;
      for (int unsigned k = 0; k < nb; k++) val[8*k +: 8] = ref_b[base + k];
      if (sg && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      exp_ld = val;
    end
    if (mis) exp_ld = '0;

    @(negedge clk);
    req_valid_M = 1'b0;
    #1;
    if (sub) begin
      check_eq("mrg_done", {31'b0, done_M}, 32'd0);
      check_eq("mrg_stall", {31'b0, stall_M}, 32'd1);
      check_eq("mrg_rd", {31'b0, Mem_Read_M}, 32'd0);
      check_eq("mrg_wr", {31'b0, Mem_Write_M}, 32'd1);
      check_eq("mrg_idx", ALU_result_M, a >> 2);
      check_eq("mrg_wdata", Write_Data_M, ref_word(a >> 2));
      @(negedge clk);
      #1;
    end
    check_eq("done", {31'b0, done_M}, 32'd1);
    check_eq("misalign", {31'b0, misalign_M}, {31'b0, mis});
    check_eq("load_data", load_data_M, exp_ld);
    check_eq("stall_after", {31'b0, stall_M}, 32'd0);
    check_eq("mem_word", mem_w[a >> 2], ref_word(a >> 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ta [0:3];
    logic [31:0] tv [0:3];
    for (int i = 0; i < 64; i++) ref_b[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem_w[i] = ref_word(i);
    exp_ld = '0;

    rst = 1'b1; req_valid_M = 1'b1; req_write_M = 1'b0; req_size_M = 2'd2;
    req_signed_M = 1'b0; addr_M = 32'h8; wdata_M = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_rd", {31'b0, Mem_Read_M}, 32'd0);
    check_eq("rst_wr", {31'b0, Mem_Write_M}, 32'd0);
    check_eq("rst_stall", {31'b0, stall_M}, 32'd0);
    check_eq("rst_done", {31'b0, done_M}, 32'd0);
    check_eq("rst_ld", load_data_M, 32'd0);
    check_eq("rst_mis", {31'b0, misalign_M}, 32'd0);
    req_valid_M = 1'b0;
    rst = 1'b0;

    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    check_eq("sw_lw", load_data_M, 32'hDEADBEEF);

    issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h6, 32'h000000AA);
    check_eq("sb_word", mem_w[1], 32'h11AA3344);

    issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h80FF7F01);
    issue(1'b0, 2'd0, 1'b1, 32'h3, 32'h0);
    check_eq("lb_s", load_data_M, 32'hFFFFFF80);
    issue(1'b0, 2'd0, 1'b0, 32'h3, 32'h0);
    check_eq("lbu", load_data_M, 32'h00000080);
    issue(1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
    check_eq("lh_s", load_data_M, 32'hFFFF80FF);

    issue(1'b0, 2'd2, 1'b0, 32'h5, 32'h0);
    issue(1'b0, 2'd3, 1'b1, 32'h7, 32'h0);

    // SH whose merge cycle is hit by reset: the write must be dropped.
    @(negedge clk);
    req_valid_M = 1'b1; req_write_M = 1'b1; req_size_M = 2'd1; req_signed_M = 1'b0;
    addr_M = 32'hA; wdata_M = 32'h0000_5A5A;
    #1;
    check_eq("rm_rd", {31'b0, Mem_Read_M}, 32'd1);
    @(negedge clk);
    req_valid_M = 1'b0;
    #1;
    check_eq("rm_stall", {31'b0, stall_M}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rm_wr", {31'b0, Mem_Write_M}, 32'd0);
    check_eq("rm_stall_rst", {31'b0, stall_M}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ld = '0;
    #1;
    check_eq("rm_done", {31'b0, done_M}, 32'd0);
    check_eq("rm_ld", load_data_M, 32'd0);
    check_eq("rm_idle", {31'b0, stall_M}, 32'd0);
    check_eq("rm_mem", mem_w[2], ref_word(2));

    for (int i = 0; i < 4; i++) begin
      ta[i] = 32'(($urandom % 16) * 4);
      tv[i] = ref_word(ta[i] >> 2);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("tp_done", {31'b0, done_M}, 32'd1);
        check_eq("tp_ld", load_data_M, tv[i-1]);
      end
      req_valid_M = 1'b1; req_write_M = 1'b0; req_size_M = 2'd2; req_signed_M = 1'b0;
      addr_M = ta[i];
      #1;
      check_eq("tp_stall", {31'b0, stall_M}, 32'd0);
      check_eq("tp_rd", {31'b0, Mem_Read_M}, 32'd1);
      check_eq("tp_idx", ALU_result_M, ta[i] >> 2);
    end
    @(negedge clk);
    check_eq("tp_done", {31'b0, done_M}, 32'd1);
    check_eq("tp_ld", load_data_M, tv[3]);
    req_valid_M = 1'b0;
    exp_ld = tv[3];
    @(negedge clk);
    check_eq("tp_done_end", {31'b0, done_M}, 32'd0);

    for (int i = 0; i < 150; i++)
      issue(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom % 64), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
